// File: rtl/crc32_pkg.sv
// Shared constants and the reference 4-bit step for the CRC-32/BZIP2 nibble engine.
// Non-reflected polynomial, MSB-first bit order.
package crc32_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT  = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'h38FB2284;

    // Four serial LFSR steps; nibble bit 3 is the first bit on the wire.
    function automatic logic [31:0] crc32_step4(input logic [31:0] lfsr,
                                                input logic [3:0]  nibble);
        logic [31:0] acc;
        logic        fb;
        acc = lfsr;
        for (int i = 3; i >= 0; i--) begin
            fb  = acc[31] ^ nibble[i];
            acc = {acc[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h00000000);
        end
        return acc;
    endfunction

endpackage

// File: rtl/crc32_nibble_comb.sv
// Purely combinational 4-bit unroll of the CRC-32 LFSR for an arbitrary polynomial.
// Processes data_in[3] first, matching MSB-first wire order.
module crc32_nibble_comb
    import crc32_pkg::*;
#(
    parameter logic [31:0] POLY = CRC32_POLY
) (
    input  logic [31:0] lfsr_in,
    input  logic [3:0]  data_in,
    output logic [31:0] lfsr_out
);

    // Unrolled next-state computation for one nibble.
    always_comb begin
        logic [31:0] acc;
        logic        fb;
        acc = lfsr_in;
        fb  = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            fb  = acc[31] ^ data_in[i];
            acc = {acc[30:0], 1'b0} ^ (fb ? POLY : 32'h00000000);
        end
        lfsr_out = acc;
    end

endmodule

// File: rtl/crc32_nibble.sv
// Streaming CRC-32/BZIP2 generator/checker, one nibble per clock.
// Holds the LFSR and valid flag; crc_out is the complemented register value.
module crc32_nibble
    import crc32_pkg::*;
#(
    parameter logic [31:0] POLY   = CRC32_POLY,
    parameter logic [31:0] INIT   = CRC32_INIT,
    parameter logic [31:0] XOROUT = CRC32_XOROUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        crc_en,
    input  logic [3:0]  data_in,
    output logic        crc_out_en,
    output logic [31:0] crc_out
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;
    logic [31:0] lfsr_step_s;
    logic        crc_out_en_q;
    logic        crc_out_en_d;

    crc32_nibble_comb #(
        .POLY (POLY)
    ) u_comb (
        .lfsr_in  (lfsr_q),
        .data_in  (data_in),
        .lfsr_out (lfsr_step_s)
    );

    // Next-state selection: fold the nibble when enabled, otherwise hold.
    always_comb begin
        lfsr_d       = lfsr_q;
        crc_out_en_d = 1'b1;
        if (crc_en) begin
            lfsr_d = lfsr_step_s;
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // State registers; reset has priority so a nibble presented with rst is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q       <= INIT;
            crc_out_en_q <= 1'b0;
        end else begin
            lfsr_q       <= lfsr_d;
            crc_out_en_q <= crc_out_en_d;
        end
    end

    assign crc_out    = lfsr_q ^ XOROUT;
    assign crc_out_en = crc_out_en_q;

endmodule

// File: tb/tb_crc32_nibble.sv
// Directed self-checking bench for crc32_nibble using known CRC-32/BZIP2 vectors.
module tb_crc32_nibble;

    logic        clk;
    logic        rst;
    logic        crc_en;
    logic [3:0]  data_in;
    logic        crc_out_en;
    logic [31:0] crc_out;

    int vectors;
    int errors;

    localparam logic [63:0] MSG     = 64'h676960D19D785A5B;
    localparam logic [31:0] MSG_CRC = 32'h96CB5E37;
    localparam logic [31:0] RESIDUE = 32'h38FB2284;

    crc32_nibble dut (
        .clk        (clk),
        .rst        (rst),
        .crc_en     (crc_en),
        .data_in    (data_in),
        .crc_out_en (crc_out_en),
        .crc_out    (crc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; crc_en = 1'b0; data_in = 4'h0;
        tick();
        rst = 1'b0;
    endtask

    task automatic feed(input logic [3:0] n);
        crc_en = 1'b1; data_in = n;
        tick();
        crc_en = 1'b0; data_in = 4'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; crc_en = 1'b0; data_in = 4'h0;
        tick(); tick();
        vectors++;
        if (crc_out !== 32'h00000000) begin
            errors++; $display("FAIL reset_crc_out got %h want %h", crc_out, 32'h00000000);
        end
        vectors++;
        if (crc_out_en !== 1'b0) begin
            errors++; $display("FAIL reset_crc_out_en got %b want %b", crc_out_en, 1'b0);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (crc_out_en !== 1'b1) begin
            errors++; $display("FAIL release_crc_out_en got %b want %b", crc_out_en, 1'b1);
        end
        vectors++;
        if (crc_out !== 32'h00000000) begin
            errors++; $display("FAIL release_crc_out got %h want %h", crc_out, 32'h00000000);
        end
    endtask

    task automatic test_message_hold();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            feed(MSG[63-4*i -: 4]);
            vectors++;
            if (crc_out_en !== 1'b1) begin
                errors++; $display("FAIL msg_en nibble %0d got %b want %b", i, crc_out_en, 1'b1);
            end
        end
        for (int h = 0; h < 2; h++) begin
            tick();
            vectors++;
            if (crc_out !== MSG_CRC) begin
                errors++; $display("FAIL msg_hold cycle %0d got %h want %h", h, crc_out, MSG_CRC);
            end
        end
    endtask

    task automatic test_residue();
        do_reset();
        for (int i = 0; i < 16; i++) feed(MSG[63-4*i -: 4]);
        for (int i = 0; i < 8; i++) feed(MSG_CRC[31-4*i -: 4]);
        tick(); tick();
        vectors++;
        if (crc_out !== RESIDUE) begin
            errors++; $display("FAIL residue got %h want %h", crc_out, RESIDUE);
        end
        vectors++;
        if (crc_out_en !== 1'b1) begin
            errors++; $display("FAIL residue_en got %b want %b", crc_out_en, 1'b1);
        end
        vectors++;
        if ($isunknown({crc_out_en, crc_out})) begin
            errors++; $display("FAIL residue_no_x got %b/%h want fully defined", crc_out_en, crc_out);
        end
    endtask

    task automatic test_gaps();
        int gap_a, gap_b, gap_c;
        logic [31:0] before_gap;
        gap_a = $urandom_range(1, 14);
        gap_b = $urandom_range(1, 14);
        gap_c = $urandom_range(1, 14);
        do_reset();
        for (int i = 0; i < 16; i++) begin
            feed(MSG[63-4*i -: 4]);
            if (i == gap_a || i == gap_b || i == gap_c) begin
                before_gap = crc_out;
                data_in = 4'hF;
                tick();
                data_in = 4'h0;
                vectors++;
                if (crc_out !== before_gap) begin
                    errors++; $display("FAIL gap_hold after %0d got %h want %h", i, crc_out, before_gap);
                end
            end
        end
        tick();
        vectors++;
        if (crc_out !== MSG_CRC) begin
            errors++; $display("FAIL gaps_final got %h want %h", crc_out, MSG_CRC);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 5; i++) feed(MSG[63-4*i -: 4]);
        do_reset();
        vectors++;
        if (crc_out !== 32'h00000000) begin
            errors++; $display("FAIL midstream_reset got %h want %h", crc_out, 32'h00000000);
        end
        for (int i = 0; i < 16; i++) feed(MSG[63-4*i -: 4]);
        tick();
        vectors++;
        if (crc_out !== MSG_CRC) begin
            errors++; $display("FAIL midstream_final got %h want %h", crc_out, MSG_CRC);
        end
    endtask

    task automatic test_rst_with_en();
        do_reset();
        for (int i = 0; i < 3; i++) feed(MSG[63-4*i -: 4]);
        rst = 1'b1; crc_en = 1'b1; data_in = 4'hF;
        tick();
        vectors++;
        if (crc_out !== 32'h00000000) begin
            errors++; $display("FAIL rst_en_crc got %h want %h", crc_out, 32'h00000000);
        end
        vectors++;
        if (crc_out_en !== 1'b0) begin
            errors++; $display("FAIL rst_en_en got %b want %b", crc_out_en, 1'b0);
        end
        rst = 1'b0; crc_en = 1'b0; data_in = 4'h0;
        tick();
        vectors++;
        if (crc_out !== 32'h00000000) begin
            errors++; $display("FAIL rst_en_after got %h want %h", crc_out, 32'h00000000);
        end
        vectors++;
        if (crc_out_en !== 1'b1) begin
            errors++; $display("FAIL rst_en_after_en got %b want %b", crc_out_en, 1'b1);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst = 1'b1; crc_en = 1'b0; data_in = 4'h0;
        test_reset();
        test_message_hold();
        test_residue();
        test_gaps();
        test_reset_midstream();
        test_rst_with_en();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
